// File: rtl/div_iter_unit.sv
// ============================================================================
// div_iter_unit : multi-cycle radix-2 restoring divider (signed/unsigned)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_sh;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_quo_fin;
  logic             w_last;

  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder is always below the divisor, so the shifted value fits
  // WIDTH+1 bits and a successful trial difference fits WIDTH bits.
  assign w_sh      = {r_rem, r_dvd[WIDTH-1]};
  assign w_fits    = (w_sh >= {1'b0, r_dvs});
  assign w_diff    = w_sh[WIDTH-1:0] - r_dvs;
  assign w_rem_nx  = w_fits ? w_diff : w_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_dvd[WIDTH-2:0], w_fits};
  assign w_rem_fin = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_quo_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_last    = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i && !annul_i)
                  w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: w_next = S_END;
      S_ON:     if (annul_i)     w_next = S_IDLE;
                else if (w_last) w_next = S_END;
      S_END:    if (!start_i)    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (w_next == S_ON) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_r <= signed_div_i & opdata1_i[WIDTH-1];
          end
        end
        S_BYZERO: begin
          result_o <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            r_cnt <= '0;
          end else begin
            r_rem <= w_rem_nx;
            r_dvd <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              result_o <= {w_rem_fin, w_quo_fin};
              ready_o  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
